// File: rtl/stack_player_pkg.sv
// Shared definitions for the stack player and the symbol stack it drains.
//   - 3-bit state encoding for the playback FSM
//   - SYMBOL_WIDTH / STACK_DEPTH, common to the stack and the player
//   - sym_onehot(): symbol to one-hot LED pattern
package stack_player_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_POP    = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_ON     = 3'd3;
    localparam logic [2:0] ST_GAP    = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    localparam int SYMBOL_WIDTH = 2;
    localparam int STACK_DEPTH  = 16;

    function automatic logic [(1 << SYMBOL_WIDTH)-1:0] sym_onehot(
        input logic [SYMBOL_WIDTH-1:0] sym
    );
        logic [(1 << SYMBOL_WIDTH)-1:0] oh;
        oh      = '0;
        oh[sym] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/stack_player_timer.sv
// Loadable down-counter with a zero flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   zero       : count is currently 0
// The count decrements every cycle and parks at 0.
module stack_player_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic                 zero
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/stack_player.sv
// Stack player: pops 2-bit symbols from the symbol stack and shows each one
// as a one-hot LED pattern for ON_CYCLES, followed by GAP_CYCLES dark.
// Pulses DONE once the stack is found empty.
//   CLK, RST_N   : clock, asynchronous active-low reset
//   START        : single-cycle playback request (ignored while BUSY)
//   ABORT        : return to IDLE at once, no DONE
//   STACK_EMPTY  : registered EMPTY flag of the stack
//   STACK_DATA   : registered DATA_OUT of the stack
//   STACK_POP    : single-cycle pop request
//   LED          : one-hot symbol, 0 when dark
//   BUSY         : high outside IDLE
//   DONE         : one-cycle completion pulse
//   SYM_COUNT    : symbols played since the last accepted START (saturating)
//   TONE         : buzzer square wave while a symbol is lit
// Optional feature macro: STACK_PLAYER_TONE_EN. Without it TONE is tied low
// and no tone divider exists.
// Every output is a flop whose D input is derived from the next state, so the
// outputs line up exactly with the state they belong to.
module stack_player
    import stack_player_pkg::*;
#(
    parameter int DATA_WIDTH  = 2,
    parameter int ON_CYCLES   = 1000,
    parameter int GAP_CYCLES  = 250,
    parameter int CNT_WIDTH   = 16,
    parameter int COUNT_WIDTH = 5,
    parameter int TONE_BASE   = 50
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         START,
    input  logic                         ABORT,
    input  logic                         STACK_EMPTY,
    input  logic [DATA_WIDTH-1:0]        STACK_DATA,
    output logic                         STACK_POP,
    output logic [(1 << DATA_WIDTH)-1:0] LED,
    output logic                         BUSY,
    output logic                         DONE,
    output logic [COUNT_WIDTH-1:0]       SYM_COUNT,
    output logic                         TONE
);

    if (DATA_WIDTH != SYMBOL_WIDTH || ON_CYCLES < 1 || GAP_CYCLES < 1 ||
        TONE_BASE < 1 || ON_CYCLES > (1 << CNT_WIDTH) ||
        GAP_CYCLES > (1 << CNT_WIDTH)) begin : g_bad_params
        $error("stack_player: inconsistent parameters");
    end

    logic [2:0]                  state_q, state_d;
    logic [DATA_WIDTH-1:0]       sym_q, sym_d;
    logic                        pop_q, pop_d;
    logic [(1 << DATA_WIDTH)-1:0] led_q, led_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [COUNT_WIDTH-1:0]      cnt_q, cnt_d;

    logic                        tmr_load;
    logic [CNT_WIDTH-1:0]        tmr_val;
    logic                        tmr_zero;

    stack_player_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // State register and all registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            sym_q   <= '0;
            pop_q   <= 1'b0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            pop_q   <= pop_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state. EMPTY is only trusted in IDLE and at the end of GAP: right
    // after a pop the stack's registered flag has not caught up yet.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (START) state_d = STACK_EMPTY ? ST_FINISH : ST_POP;
            ST_POP:    state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_ON;
            ST_ON:     if (tmr_zero) state_d = ST_GAP;
            ST_GAP:    if (tmr_zero) state_d = STACK_EMPTY ? ST_FINISH : ST_POP;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        // ABORT wins everywhere, including over START in IDLE.
        if (ABORT) begin
            state_d = ST_IDLE;
        end
    end

    // Timer, symbol, counter and output next values.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        sym_d    = sym_q;
        cnt_d    = cnt_q;

        if (state_q == ST_LOAD) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_WIDTH'(ON_CYCLES - 1);
            sym_d    = STACK_DATA;
        end else if (state_q == ST_ON && tmr_zero) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_WIDTH'(GAP_CYCLES - 1);
        end

        if (state_q == ST_IDLE && state_d != ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_LOAD && state_d == ST_ON && cnt_q != '1) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end

        pop_d  = (state_d == ST_POP);
        led_d  = (state_d == ST_ON) ? sym_onehot(sym_d) : '0;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FINISH);
    end

`ifdef STACK_PLAYER_TONE_EN
    logic                 tone_q, tone_d;
    logic                 tone_load;
    logic [CNT_WIDTH-1:0] tone_val;
    logic                 tone_zero;

    stack_player_timer #(.CNT_WIDTH(CNT_WIDTH)) u_tone_div (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (tone_load),
        .load_val (tone_val),
        .zero     (tone_zero)
    );

    // Half period is TONE_BASE*(symbol+1); the divider restarts on ON entry
    // so every symbol begins with TONE low.
    always_comb begin
        tone_d    = 1'b0;
        tone_load = 1'b0;
        tone_val  = CNT_WIDTH'(TONE_BASE * (int'(sym_d) + 1) - 1);
        if (state_d == ST_ON) begin
            if (state_q != ST_ON) begin
                tone_load = 1'b1;
            end else if (tone_zero) begin
                tone_load = 1'b1;
                tone_d    = ~tone_q;
            end else begin
                tone_d    = tone_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tone_q <= 1'b0;
        end else begin
            tone_q <= tone_d;
        end
    end

    assign TONE = tone_q;
`else
    assign TONE = 1'b0;
`endif

    assign STACK_POP = pop_q;
    assign LED       = led_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign SYM_COUNT = cnt_q;

endmodule

// File: tb/tb_stack_player.sv
// Bench for stack_player with ON_CYCLES=4, GAP_CYCLES=2, COUNT_WIDTH=2
// (so counter saturation is reachable) and TONE_BASE=2.
// A behavioural stack feeds the DUT. For each playback the expected per-cycle
// output trace is generated from the stack contents: per symbol one pop cycle,
// one load cycle, ON_CYCLES lit, GAP_CYCLES dark; then DONE, then idle.
module tb_stack_player;

  localparam int ON_C    = 4;
  localparam int GAP_C   = 2;
  localparam int CW      = 2;
  localparam int TB_BASE = 2;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int W       = CW + 8;

  logic          CLK   = 1'b0;
  logic          RST_N = 1'b0;
  logic          START = 1'b0;
  logic          ABORT = 1'b0;
  logic          stk_empty = 1'b1;
  logic [1:0]    stk_data  = 2'd0;
  logic          STACK_POP;
  logic [3:0]    LED;
  logic          BUSY;
  logic          DONE;
  logic [CW-1:0] SYM_COUNT;
  logic          TONE;

  int vectors     = 0;
  int miscompares = 0;
  int last_cnt    = 0;

  logic [1:0]   stk_q[$];
  int           play_syms[$];
  logic [W-1:0] exp_q[$];
  logic         pop_seen = 1'b0;

  stack_player #(
    .DATA_WIDTH (2),
    .ON_CYCLES  (ON_C),
    .GAP_CYCLES (GAP_C),
    .CNT_WIDTH  (16),
    .COUNT_WIDTH(CW),
    .TONE_BASE  (TB_BASE)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .ABORT      (ABORT),
    .STACK_EMPTY(stk_empty),
    .STACK_DATA (stk_data),
    .STACK_POP  (STACK_POP),
    .LED        (LED),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .SYM_COUNT  (SYM_COUNT),
    .TONE       (TONE)
  );

  // clock / reset-independent stack model
  always #5 CLK = ~CLK;

  always @(negedge CLK) pop_seen <= STACK_POP;

  always @(posedge CLK) begin
    if (pop_seen && stk_q.size() != 0) stk_data <= stk_q.pop_front();
    stk_empty <= (stk_q.size() == 0);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] obs();
    return {SYM_COUNT, STACK_POP, LED, BUSY, DONE, TONE};
  endfunction

  function automatic logic [W-1:0] ent(input int c, input logic p, input int l,
                                       input logic b, input logic d, input logic t);
    logic [CW-1:0] cc;
    logic [3:0]    ll;
    cc = CW'(c);
    ll = 4'(l);
    return {cc, p, ll, b, d, t};
  endfunction

  function automatic int sat(input int i);
    return (i > CNT_MAX) ? CNT_MAX : i;
  endfunction

  function automatic logic tone_exp(input int s, input int j);
`ifdef STACK_PLAYER_TONE_EN
    return ((j / (TB_BASE * (s + 1))) % 2) == 1;
`else
    return (s < 0) && (j < 0);
`endif
  endfunction

  task automatic build_trace();
    int n;
    exp_q.delete();
    n = play_syms.size();
    for (int i = 0; i < n; i++) begin
      int s;
      s = play_syms[i];
      exp_q.push_back(ent(sat(i), 1'b1, 0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(ent(sat(i), 1'b0, 0, 1'b1, 1'b0, 1'b0));
      for (int j = 0; j < ON_C; j++)
        exp_q.push_back(ent(sat(i + 1), 1'b0, 1 << s, 1'b1, 1'b0, tone_exp(s, j)));
      for (int j = 0; j < GAP_C; j++)
        exp_q.push_back(ent(sat(i + 1), 1'b0, 0, 1'b1, 1'b0, 1'b0));
    end
    exp_q.push_back(ent(sat(n), 1'b0, 0, 1'b1, 1'b1, 1'b0));
    exp_q.push_back(ent(sat(n), 1'b0, 0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(ent(sat(n), 1'b0, 0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic load_stack();
    stk_q.delete();
    foreach (play_syms[i]) stk_q.push_back(2'(play_syms[i]));
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // driver: START pulse, then check one trace entry per cycle
  task automatic run_play(input int abort_at, input int stray_at, input int reset_at);
    build_trace();
    if (abort_at >= 0) begin
      int held;
      held = int'(exp_q[abort_at][W-1 -: CW]);
      for (int k = abort_at + 1; k < exp_q.size(); k++)
        exp_q[k] = ent(held, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    end
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      check_val($sformatf("play[%0d]", k), 16'(obs()), 16'(exp_q[k]));
      if (k == reset_at) begin
        #3;
        RST_N = 1'b0;
        #1;
        check_val("async_reset", 16'(obs()), 16'd0);
        @(posedge CLK);
        #1;
        check_val("held_reset", 16'(obs()), 16'd0);
        RST_N    = 1'b1;
        last_cnt = 0;
        return;
      end
      if (k == abort_at) ABORT = 1'b1;
      if (k == stray_at) START = 1'b1;
      @(posedge CLK);
      #1;
      ABORT = 1'b0;
      START = 1'b0;
      if (abort_at >= 0 && k >= abort_at + 3) break;
    end
    last_cnt = int'(exp_q[exp_q.size() - 1][W-1 -: CW]);
  endtask

  initial begin
    // reset state, before any clock edge
    #2;
    check_val("reset_state", 16'(obs()), 16'd0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    check_val("idle_after_reset", 16'(obs()), 16'd0);

    // empty stack: DONE only, no pop
    play_syms = {};
    load_stack();
    run_play(-1, -1, -1);

    // three-symbol playback
    play_syms = {3, 1, 0};
    load_stack();
    run_play(-1, -1, -1);

    // abort on the 2nd cycle of the second ON period
    play_syms = {3, 1, 0};
    load_stack();
    run_play(11, -1, -1);
    check_val("abort_count", 16'(SYM_COUNT), 16'd2);

    // asynchronous reset during ON, then a clean replay
    play_syms = {2, 1};
    load_stack();
    run_play(-1, -1, 4);
    play_syms = {2, 1};
    load_stack();
    run_play(-1, -1, -1);

    // START during GAP is ignored
    play_syms = {1, 3, 2};
    load_stack();
    run_play(-1, 6, -1);

    // START together with ABORT in IDLE: nothing happens, count kept
    play_syms = {2};
    load_stack();
    START = 1'b1;
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    ABORT = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_val($sformatf("start_abort_idle[%0d]", k), 16'(obs()),
                16'(ent(last_cnt, 1'b0, 0, 1'b0, 1'b0, 1'b0)));
      @(posedge CLK);
      #1;
    end

    // counter saturation
    play_syms = {0, 1, 2, 3, 2, 1};
    load_stack();
    run_play(-1, -1, -1);

    // randomized playbacks with occasional abort / stray START
    for (int r = 0; r < 15; r++) begin
      int n, len, ab, st;
      n = $urandom_range(0, 6);
      play_syms.delete();
      for (int i = 0; i < n; i++) play_syms.push_back($urandom_range(0, 3));
      len = n * (ON_C + GAP_C + 2) + 3;
      ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      st  = (ab < 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, len - 3) : -1;
      load_stack();
      run_play(ab, st, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stack_player.md
Name: stack_player

Overview:
- Downstream consumer of the 2-bit symbol stack.
- On START it pops symbols one at a time and shows each as a one-hot LED pattern for a fixed on-time, followed by a dark gap.
- Stops when the stack reports empty, then pulses DONE.
- Drives the stack's POP input and reads its registered DATA_OUT and EMPTY outputs.

Parameters:
- DATA_WIDTH, 2: symbol width; must match the stack.
- ON_CYCLES, 1000: cycles each LED pattern is lit; must be >=1.
- GAP_CYCLES, 250: dark cycles after each symbol; must be >=1.
- CNT_WIDTH, 16: timer width; must hold max(ON_CYCLES, GAP_CYCLES).
- COUNT_WIDTH, 5: width of the played-symbol counter.
- TONE_BASE, 50: tone half-period unit; used only with the optional feature.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  single-cycle request to begin playback
- ABORT  in  1  stop playback immediately; no DONE pulse
- STACK_EMPTY  in  1  stack EMPTY output
- STACK_DATA  in  DATA_WIDTH  stack DATA_OUT
- STACK_POP  out  1  single-cycle pop request to the stack
- LED  out  2**DATA_WIDTH  one-hot symbol display; 0 when dark
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse when playback completes
- SYM_COUNT  out  COUNT_WIDTH  symbols played since the last START
- TONE  out  1  buzzer square wave; constant 0 unless the optional feature is enabled

Behaviour:
- Reset (async, RST_N low) forces state IDLE; STACK_POP, LED, BUSY, DONE, SYM_COUNT, TONE, timer and symbol register all 0. This takes effect immediately, without waiting for a clock edge.
- All outputs are registered. STACK_POP is asserted only in state POP.
- State machine (IDLE, POP, LOAD, ON, GAP, FINISH):
  - IDLE: on START, go to POP if STACK_EMPTY=0, else FINISH. SYM_COUNT clears to 0 on accepted START.
  - POP: STACK_POP=1 for one cycle -> LOAD.
  - LOAD: stack DATA_OUT is valid this cycle. Capture STACK_DATA, load timer with ON_CYCLES-1, increment SYM_COUNT (saturating at its max) -> ON.
  - ON: LED = 1 << symbol. When the timer reaches 0, load GAP_CYCLES-1 -> GAP.
  - GAP: LED = 0. When the timer reaches 0, sample STACK_EMPTY: 1 -> FINISH, 0 -> POP.
  - FINISH: DONE=1 for one cycle -> IDLE.
- Latency:
  - START to first STACK_POP: 1 cycle.
  - STACK_POP to LED lit: 2 cycles.
  - Full symbol period: ON_CYCLES + GAP_CYCLES + 2 cycles.
- STACK_EMPTY is sampled only in IDLE (at START) and at the end of GAP, never directly after a pop, because the stack's EMPTY flag is registered.
- ABORT in any non-IDLE state -> IDLE on the next edge: LED 0, no DONE, no further POP. SYM_COUNT holds its value.
- START while BUSY is ignored.
- START and ABORT together in IDLE: ABORT wins and the block stays in IDLE.
- The block never asserts a push; stack contents are consumed destructively.

Optional Feature:
- Macro: STACK_PLAYER_TONE_EN.
- Defined: during ON, TONE toggles every TONE_BASE*(symbol+1) cycles, starting low on entry to ON. TONE is 0 in every other state and on ABORT.
- Not defined: TONE is tied to 0 and no divider logic is synthesized. The port list is unchanged either way.

Decomposition:
- Shared package/header holds:
  - state encoding localparams (3-bit)
  - SYMBOL_WIDTH=2 and STACK_DEPTH=16, shared with the stack
  - the symbol-to-one-hot decode function
- One natural sub-module: stack_player_timer, a loadable down-counter (CNT_WIDTH) with a zero flag. It is reused for ON/GAP timing and for the tone divider.

Test Plan:
Bench parameters: ON_CYCLES=4, GAP_CYCLES=2, behavioural stack model.
1. STACK_EMPTY=1, START pulse -> no STACK_POP; DONE high exactly 1 cycle, in the cycle after START is sampled; SYM_COUNT=0; BUSY high 1 cycle.
2. Stack holds 11, 01, 00 (top first), START -> three STACK_POP pulses 8 cycles apart. LED shows 1000 x4, 0000 x2, 0010 x4, 0000 x2, 0001 x4, 0000 x2. Then DONE once, SYM_COUNT=3, BUSY low.
3. ABORT on the 2nd cycle of the second ON -> LED=0 and BUSY=0 the next cycle; no DONE; no third POP; SYM_COUNT=2.
4. RST_N driven low between edges during ON -> LED, BUSY, STACK_POP, SYM_COUNT=0 immediately. After release, START replays correctly.
5. START pulsed during GAP -> ignored, sequence unchanged. START+ABORT in IDLE -> no POP, BUSY stays 0.
6. STACK_PLAYER_TONE_EN defined, TONE_BASE=2, symbol 01, ON_CYCLES=16 -> TONE toggles every 4 cycles while LED=0010; TONE=0 during GAP.
